// File: rtl/pmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmu_pkg
// Brief    : Shared constants, counter type and index helper for the PMU bank.
// Revision : 1.0 - initial release
// ============================================================================
package pmu_pkg;

    localparam int unsigned c_reg_width_default  = 32;
    localparam int unsigned c_n_counters_default = 9;

    typedef logic [c_reg_width_default-1:0] counter_t;

    // True when a write index addresses an implemented counter.
    function automatic logic idx_valid(input int unsigned idx,
                                       input int unsigned n_counters);
        return (idx < n_counters);
    endfunction

endpackage : pmu_pkg
`default_nettype wire

// File: rtl/pmu_counter_cell.sv
`default_nettype none
// ============================================================================
// Module   : pmu_counter_cell
// Brief    : One event counter with its sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_counter_cell
    import pmu_pkg::*;
#(
    parameter int unsigned REG_WIDTH = c_reg_width_default
) (
    input  logic                 clk_i,
    input  logic                 clr,
    input  logic                 we,
    input  logic [REG_WIDTH-1:0] wdata,
    input  logic                 inc,
    input  logic                 ovf_clr,
    output logic [REG_WIDTH-1:0] value,
    output logic                 ovf
);

    logic [REG_WIDTH-1:0] r_value;
    logic                 r_ovf;
    logic                 w_wrap;

    // A write steals the cycle, so an increment that would have wrapped is
    // discarded together with its overflow.
    assign w_wrap = inc && !we && (r_value == {REG_WIDTH{1'b1}});

    always_ff @(posedge clk_i) begin
        if (clr) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (we) begin
                r_value <= wdata;
            end else if (inc) begin
                r_value <= r_value + {{(REG_WIDTH-1){1'b0}}, 1'b1};
            end

            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign value = r_value;
    assign ovf   = r_ovf;

endmodule : pmu_counter_cell
`default_nettype wire

// File: rtl/pmu_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : pmu_counter_bank
// Brief    : Bank of free-running event counters with preload, sticky
//            overflow flags and a masked overflow interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_counter_bank
    import pmu_pkg::*;
#(
    parameter  int unsigned REG_WIDTH  = c_reg_width_default,
    parameter  int unsigned N_COUNTERS = c_n_counters_default,
    localparam int unsigned IDX_W      = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  softrst_i,
    input  logic                  en_i,
    input  logic [N_COUNTERS-1:0] events_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [REG_WIDTH-1:0]  wr_data_i,
    input  logic [N_COUNTERS-1:0] ovf_clr_i,
    input  logic [N_COUNTERS-1:0] ovf_mask_i,
    output logic [REG_WIDTH-1:0]  counter_value_o [0:N_COUNTERS-1],
    output logic [N_COUNTERS-1:0] overflow_o,
    output logic                  intr_overflow_o
);

    logic [N_COUNTERS-1:0] r_events_q;
    logic [N_COUNTERS-1:0] w_we;
    logic [N_COUNTERS-1:0] w_ovf;
    logic                  w_clr;
    logic                  w_idx_ok;

    // Hard and soft reset have identical effect, so they share one clear.
    assign w_clr    = rst_i | softrst_i;
    assign w_idx_ok = idx_valid(int'(wr_idx_i), N_COUNTERS);

    // Probe pulses are retimed once; enable is applied with the pulse so a
    // late drop of en_i does not cancel events already captured.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_events_q <= '0;
        end else begin
            r_events_q <= events_i & {N_COUNTERS{en_i}};
        end
    end

    for (genvar n = 0; n < N_COUNTERS; n++) begin : g_cell
        assign w_we[n] = we_i && w_idx_ok && (wr_idx_i == IDX_W'(n));

        pmu_counter_cell #(
            .REG_WIDTH (REG_WIDTH)
        ) u_cell (
            .clk_i   (clk_i),
            .clr     (w_clr),
            .we      (w_we[n]),
            .wdata   (wr_data_i),
            .inc     (r_events_q[n]),
            .ovf_clr (ovf_clr_i[n]),
            .value   (counter_value_o[n]),
            .ovf     (w_ovf[n])
        );
    end : g_cell

    assign overflow_o      = w_ovf;
    assign intr_overflow_o = |(w_ovf & ovf_mask_i);

endmodule : pmu_counter_bank
`default_nettype wire
